// File: rtl/cla_pkg.sv
// Shared lookahead equations for the carry-lookahead adder: 4-bit carry
// generation and group generate, reused at every level of the tree.
package cla_pkg;

  localparam int GROUP_W = 4;

  // Carries into each of four positions, c[0] = cin, all in flat lookahead form.
  function automatic logic [3:0] la_carry(input logic [3:0] g, input logic [3:0] p,
                                          input logic cin);
    logic [3:0] c;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    return c;
  endfunction

  function automatic logic grp_gen(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  // Number of 4-ary lookahead levels needed above ng groups.
  function automatic int num_levels(input int ng);
    int n;
    int l;
    n = ng;
    l = 0;
    while (n > 1) begin
      n = (n + 3) / 4;
      l++;
    end
    return l;
  endfunction

endpackage

// File: rtl/cla4.sv
// 4-bit lookahead adder group: sum bits plus group generate/propagate.
module cla4
  import cla_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               cin,
  output logic [GROUP_W-1:0] s,
  output logic               gg,
  output logic               gp
);

  logic [GROUP_W-1:0] g, p, c;

  assign g  = a & b;
  assign p  = a ^ b;
  assign c  = la_carry(g, p, cin);
  assign s  = p ^ c;
  assign gg = grp_gen(g, p);
  assign gp = &p;

endmodule

// File: rtl/cla.sv
// Registered carry-lookahead adder: groups of cla4 joined by a 4-ary lookahead
// tree; {cout, sum} = A + B + Cin, captured one clock later.
module cla
  import cla_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NG  = WIDTH / GROUP_W;
  localparam int NLV = num_levels(NG);
  localparam int NP  = 4 * NG;

  logic [NG-1:0]    gg, gp, cg;
  logic [WIDTH-1:0] s_nxt;
  logic             co_nxt;

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    cla4 u_grp (
      .a   (A[gi*GROUP_W +: GROUP_W]),
      .b   (B[gi*GROUP_W +: GROUP_W]),
      .cin (cg[gi]),
      .s   (s_nxt[gi*GROUP_W +: GROUP_W]),
      .gg  (gg[gi]),
      .gp  (gp[gi])
    );
  end

  // Level 0 is the groups; each higher level folds four nodes into one.
  // Arrays are padded to 4*NG so a node's four children are always addressable.
  always_comb begin
    logic [NP-1:0] gv [NLV+1];
    logic [NP-1:0] pv [NLV+1];
    logic [NP-1:0] cv [NLV+1];
    int            n  [NLV+1];
    logic [3:0]    g4, p4, c4;
    for (int l = 0; l <= NLV; l++) begin
      gv[l] = '0;
      pv[l] = '0;
      cv[l] = '0;
      n[l]  = 0;
    end
    g4 = '0;
    p4 = '0;
    c4 = '0;
    n[0] = NG;
    gv[0][NG-1:0] = gg;
    pv[0][NG-1:0] = gp;
    for (int l = 0; l < NLV; l++) begin
      n[l+1] = (n[l] + 3) / 4;
      for (int k = 0; k < NG; k++) begin
        if (k < n[l+1]) begin
          g4 = gv[l][4*k +: 4];
          p4 = pv[l][4*k +: 4];
          gv[l+1][k] = grp_gen(g4, p4);
          pv[l+1][k] = &p4;
        end
      end
    end
    // Carries flow back down the tree, Cin entering at the root.
    cv[NLV][0] = Cin;
    for (int l = NLV; l > 0; l--) begin
      for (int k = 0; k < NG; k++) begin
        if (k < n[l]) begin
          g4 = gv[l-1][4*k +: 4];
          p4 = pv[l-1][4*k +: 4];
          c4 = la_carry(g4, p4, cv[l][k]);
          cv[l-1][4*k +: 4] = c4;
        end
      end
    end
    cg     = cv[0][NG-1:0];
    co_nxt = gv[NLV][0] | (pv[NLV][0] & Cin);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      sum  <= s_nxt;
      cout <= co_nxt;
    end
  end

endmodule

// File: tb/tb_cla.sv
// Bench for cla: a 4-bit and a 16-bit instance driven in lockstep, expected
// results queued at drive time and popped one cycle later.
module tb_cla;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  a4 = '0, b4 = '0, s4;
  logic        c4 = 1'b0, co4;
  logic [15:0] a16 = '0, b16 = '0, s16;
  logic        c16 = 1'b0, co16;

  always #5 clk = ~clk;

  cla #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .A(a4), .B(b4), .Cin(c4), .sum(s4), .cout(co4)
  );
  cla #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .A(a16), .B(b16), .Cin(c16), .sum(s16), .cout(co16)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       ci;
    logic [3:0] s;
    logic       co;
  } vec_t;

  int total = 0;
  int bad   = 0;
  logic [4:0]  q4  [$];
  logic [16:0] q16 [$];

  function automatic logic [16:0] m16(input logic [15:0] a, input logic [15:0] b,
                                      input logic ci);
    return {1'b0, a} + {1'b0, b} + {16'b0, ci};
  endfunction

  task automatic check(input string nm, input logic [16:0] got, input logic [16:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  // One transaction on both instances; results compared after the next edge.
  task automatic step(input logic [3:0] a, input logic [3:0] b, input logic ci,
                      input logic [4:0] e4, input logic [15:0] xa, input logic [15:0] xb,
                      input logic xc, input logic [16:0] e16);
    logic [4:0]  x4;
    logic [16:0] x16;
    @(negedge clk);
    a4 = a; b4 = b; c4 = ci;
    a16 = xa; b16 = xb; c16 = xc;
    q4.push_back(e4);
    q16.push_back(e16);
    @(posedge clk);
    #1;
    x4  = q4.pop_front();
    x16 = q16.pop_front();
    check("add4",  {12'b0, co4, s4}, {12'b0, x4});
    check("add16", {co16, s16}, x16);
  endtask

  task automatic rstep(input logic [3:0] a, input logic [3:0] b, input logic ci,
                       input logic [4:0] e4);
    logic [15:0] xa, xb;
    logic        xc;
    xa = 16'($urandom);
    xb = 16'($urandom);
    xc = 1'($urandom_range(0, 1));
    step(a, b, ci, e4, xa, xb, xc, m16(xa, xb, xc));
  endtask

  initial begin
    vec_t tbl [8];
    tbl[0] = '{4'b1100, 4'b1010, 1'b0, 4'b0110, 1'b1};
    tbl[1] = '{4'b1110, 4'b1011, 1'b1, 4'b1010, 1'b1};
    tbl[2] = '{4'b1010, 4'b1000, 1'b1, 4'b0011, 1'b1};
    tbl[3] = '{4'b0010, 4'b1000, 1'b0, 4'b1010, 1'b0};
    tbl[4] = '{4'b1001, 4'b0010, 1'b0, 4'b1011, 1'b0};
    tbl[5] = '{4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1};
    tbl[6] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1};
    tbl[7] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0};

    // Reset state with nonzero inputs present.
    a4 = 4'hF; b4 = 4'h1; a16 = 16'hFFFF; b16 = 16'h0001;
    repeat (2) @(negedge clk);
    check("rst4",  {12'b0, co4, s4}, 17'h0);
    check("rst16", {co16, s16}, 17'h0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      rstep(tbl[i].a, tbl[i].b, tbl[i].ci, {tbl[i].co, tbl[i].s});

    // Wide boundaries: full propagate, all ones, all zeros.
    step(4'h0, 4'h0, 1'b0, 5'h00, 16'hFFFF, 16'h0001, 1'b0, 17'h10000);
    step(4'h0, 4'h0, 1'b1, 5'h01, 16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF);
    step(4'h0, 4'h0, 1'b0, 5'h00, 16'h0000, 16'h0000, 1'b0, 17'h00000);
    step(4'hF, 4'h0, 1'b1, 5'h10, 16'hFFFF, 16'h0000, 1'b1, 17'h10000);

    // Mid-cycle asynchronous reset discards the in-flight result.
    rstep(4'b1111, 4'b1111, 1'b1, 5'b11111);
    @(negedge clk);
    a4 = 4'hE; b4 = 4'h7; c4 = 1'b1; a16 = 16'hF0F0; b16 = 16'h1234; c16 = 1'b1;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst4",  {12'b0, co4, s4}, 17'h0);
    check("arst16", {co16, s16}, 17'h0);
    @(posedge clk);
    #1;
    check("hold4",  {12'b0, co4, s4}, 17'h0);
    check("hold16", {co16, s16}, 17'h0);
    @(negedge clk);
    rst = 1'b0;
    rstep(4'b1010, 4'b0101, 1'b1, 5'b10000);

    // Exhaustive 4-bit sweep alongside random 16-bit vectors.
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          rstep(4'(a), 4'(b), 1'(c), 5'(a + b + c));

    for (int i = 0; i < 10000; i++) begin
      logic [3:0] ra, rb;
      logic       rc;
      ra = 4'($urandom);
      rb = 4'($urandom);
      rc = 1'($urandom_range(0, 1));
      rstep(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {4'b0, rc});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
